instr_encoder: RTL



---
 rtl/instr_encoder.sv | 96 +++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: validates opcode and immediate range, packs fields into a
// 19-bit word, and streams accepted words into instruction memory at increasing addresses.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    input  logic [1:0]        funct,
    input  logic [9:0]        imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [18:0]       imem_wdata,
    output logic              err,
    output logic              err_pulse,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [0:0] FILLING = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]    state;
    logic          legal_op;
    logic          imm_ok;
    logic [18:0]   word;
    logic          accept;
    logic [ADDR_W:0] count_inc;

    assign full      = (state == FULL);
    assign in_ready  = !full && !clr;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + (ADDR_W+1)'(1);

    // Format selection by opcode; only JAL carries the full 10-bit immediate,
    // every other format needs imm to sign-extend from its low 6 bits.
    always_comb begin
        legal_op = 1'b1;
        imm_ok   = (imm[9:5] == 5'b00000) || (imm[9:5] == 5'b11111);
        word     = '0;
        case (op)
            5'b00001: word = {op, rd, rs1, rs2, funct};
            5'b00010, 5'b00011, 5'b00101, 5'b00110,
            5'b00111, 5'b01001, 5'b01010, 5'b01011:
                word = {op, rd, rs1, imm[5:0]};
            5'b00100: word = {op, rs2, rs1, imm[5:0]};
            5'b01000, 5'b01110:
                word = {op, rs1, rs2, imm[5:0]};
            5'b10000: begin
                word   = {op, rd, imm};
                imm_ok = 1'b1;
            end
            default: legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILLING;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            err_pulse <= 1'b0;
            if (clr) begin
                state <= FILLING;
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal_op && imm_ok) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= count[ADDR_W-1:0];
                    imem_wdata <= word;
                    count      <= count_inc;
                    // The carry into the top count bit means every address has been used.
                    if (count_inc[ADDR_W])
                        state <= FULL;
                end else begin
                    err_pulse <= 1'b1;
                    err       <= 1'b1;
                end
            end
        end
    end

endmodule
